fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; power of two, minimum 2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, fetch address loaded at reset.
REQ-003 Parameter PC_STEP, default 1, PC increment per fetched word; the instruction address is a word index.
REQ-004 clk_i  input  1  single clock; all state updates on posedge.
REQ-005 rst_i  input  1  reset; synchronous, active-high.
REQ-006 addr_o  output  32  fetch PC, driven combinationally from the PC register to i_cache addr_in_pipeline_i.
REQ-007 icache_valid_i  input  1  i_cache pipeline_valid_o; icache_data_i is usable this cycle.
REQ-008 icache_data_i  input  32  i_cache data_out_pipeline_o for addr_o.
REQ-009 redirect_i  input  1  branch/jump redirect request from downstream.
REQ-010 redirect_pc_i  input  32  redirect target.
REQ-011 instr_o  output  32  head-entry instruction to decode.
REQ-012 pc_o  output  32  head-entry PC.
REQ-013 valid_o  output  1  head entry valid.
REQ-014 ready_i  input  1  decode accepts the head entry this cycle.

Function
REQ-015 The block SHALL hold up to DEPTH {pc, instr} entries in FIFO order, with separate read and write pointers and an occupancy count of width $clog2(DEPTH)+1.
REQ-016 The push condition SHALL be icache_valid_i && !redirect_i && (!full || pop).
REQ-017 The pop condition SHALL be valid_o && ready_i && !redirect_i.
REQ-018 On push, the block SHALL write {addr_o, icache_data_i} at the write pointer and advance the PC by PC_STEP, modulo 2^32.
REQ-019 When full with no pop, the PC SHALL hold and addr_o SHALL stay stable.
REQ-020 Simultaneous push and pop SHALL leave the count unchanged, including at full and at empty (count 0 with pop impossible).
REQ-021 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-022 valid_o SHALL equal (count != 0), with no combinational path from icache_valid_i to valid_o.
REQ-023 Minimum latency from push to valid_o SHALL be 1 cycle.
REQ-024 FSM states SHALL be RUN and FLUSH.
REQ-025 redirect_i in RUN SHALL, next cycle, clear count and both pointers, load the PC with redirect_pc_i, and enter FLUSH.
REQ-026 In FLUSH, no push or pop SHALL occur, valid_o SHALL be 0, and the next state SHALL be RUN.
REQ-027 redirect_i has priority over push and pop in every state; redirect_i in FLUSH reloads the PC and stays in FLUSH.
REQ-028 The PC SHALL be modified only by reset, redirect, or push.

Reset
REQ-029 rst_i SHALL set PC=RESET_PC, count=0, pointers=0, state=RUN, valid_o=0, and counters=0 on the next clock edge.
REQ-030 rst_i SHALL override redirect_i, push, and pop in the same cycle.
REQ-031 rst_i asserted mid-stream SHALL discard all queued entries.
REQ-032 instr_o and pc_o SHALL be 0 in reset.

Configuration
REQ-033 With FETCH_QUEUE_STATS_EN defined, the block SHALL add three 32-bit saturating output counters:
- stall_cycles_o, counting cycles with icache_valid_i && full && !pop;
- empty_cycles_o, counting cycles with valid_o==0 in RUN;
- redirect_count_o, counting accepted redirects.
REQ-034 Without FETCH_QUEUE_STATS_EN, those ports and their logic SHALL be absent, with no other behavioural difference.

Structure
REQ-035 Package fetch_pkg SHALL hold fetch_entry_t {pc[31:0], instr[31:0]}, the state enum (RUN, FLUSH), and a RESET_PC default constant shared with i_cache benches.
REQ-036 Storage and pointers SHALL live in sub-module fetch_fifo (parameter DEPTH, type fetch_entry_t; ports push, pop, flush, full, empty, head).
REQ-037 fetch_queue SHALL own the PC, FSM, and counters.

Verification
REQ-038 Reset then icache_valid_i=1, ready_i=1 with memory word n = 32'hA000_0000+n -> pc_o 0,1,2,... with instr_o A000_0000,... one per cycle from cycle 2.
REQ-039 ready_i=0 with icache always valid -> exactly 4 pushes; addr_o frozen at 4; valid_o=1; then ready_i=1 -> pc_o 0..3 then 4, no loss or duplicate.
REQ-040 Queue holding 3 entries, redirect_i=1 with redirect_pc_i=32'h100 -> next cycle valid_o=0 and addr_o=32'h100; cycle after, FLUSH->RUN; first output pc_o=32'h100.
REQ-041 Full queue with ready_i=1 and icache_valid_i=1 for 10 cycles -> count stays 4 every cycle; PC sequence continuous across pointer wrap.
REQ-042 rst_i=1 while full and redirect_i=1 -> next cycle valid_o=0, addr_o=RESET_PC, state RUN.
REQ-043 With FETCH_QUEUE_STATS_EN defined, 5 full-stall cycles and 2 redirects -> stall_cycles_o=5 and redirect_count_o=2.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
//   fetch_entry_t    : one queued fetch result {pc, instr}
//   fetch_state_e    : fetch queue control state (RUN, FLUSH)
//   FETCH_RESET_PC   : default reset fetch address, also used by i_cache benches
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_e;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Entry storage for the fetch queue: DEPTH-entry circular FIFO.
//   clk_i, rst_i : clock, synchronous active-high reset (clears pointers/count)
//   push, wdata  : write wdata at the write pointer (caller guarantees room or pop)
//   pop          : drop the head entry (caller guarantees non-empty)
//   flush        : empty the queue; wins over push/pop
//   full, empty  : occupancy flags
//   head         : entry at the read pointer (don't-care when empty)
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   push,
    input  logic   pop,
    input  logic   flush,
    input  entry_t wdata,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    // DEPTH is a power of two, so the natural pointer overflow wraps DEPTH-1 -> 0.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; a push at full is only allowed with a pop,
    // and the head is read before this edge overwrites its slot.
    always_ff @(posedge clk_i) begin
        if (push && !flush && !rst_i) mem[wr_ptr] <= wdata;
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue between i_cache and decode: owns the fetch PC, the RUN/FLUSH
// control FSM and optional statistics counters; entries live in fetch_fifo.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   addr_o                : fetch PC to i_cache
//   icache_valid_i/data_i : i_cache result for addr_o
//   redirect_i/pc_i       : downstream redirect request and target
//   instr_o, pc_o, valid_o: head entry to decode (instr/pc forced 0 when empty)
//   ready_i               : decode accepts the head entry
//   stall_cycles_o, empty_cycles_o, redirect_count_o : saturating counters,
//                           present only when FETCH_QUEUE_STATS_EN is defined
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
    parameter logic [31:0] PC_STEP  = 32'd1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] addr_o,
    input  logic        icache_valid_i,
    input  logic [31:0] icache_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        valid_o,
    input  logic        ready_i
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [31:0] stall_cycles_o,
    output logic [31:0] empty_cycles_o,
    output logic [31:0] redirect_count_o
`endif
);

    fetch_state_e state, state_nxt;
    logic [31:0]  pc_q;
    logic         full, empty, push, pop;
    fetch_entry_t head, wentry;

    assign addr_o  = pc_q;
    // valid_o depends on registered occupancy only, never on icache_valid_i.
    assign valid_o = !empty;
    assign pop     = valid_o && ready_i && !redirect_i;
    assign push    = icache_valid_i && !redirect_i && (state == RUN) && (!full || pop);
    assign wentry  = '{pc: pc_q, instr: icache_data_i};
    assign instr_o = valid_o ? head.instr : 32'h0;
    assign pc_o    = valid_o ? head.pc    : 32'h0;

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .pop   (pop),
        .flush (redirect_i),
        .wdata (wentry),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= RUN;
        else       state <= state_nxt;
    end

    // FLUSH lasts one cycle unless another redirect arrives.
    always_comb begin
        state_nxt = state;
        if (redirect_i)          state_nxt = FLUSH;
        else if (state == FLUSH) state_nxt = RUN;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)           pc_q <= RESET_PC;
        else if (redirect_i) pc_q <= redirect_pc_i;
        else if (push)       pc_q <= pc_q + PC_STEP;
    end

`ifdef FETCH_QUEUE_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cycles_o   <= '0;
            empty_cycles_o   <= '0;
            redirect_count_o <= '0;
        end else begin
            if (icache_valid_i && full && !pop)  stall_cycles_o   <= sat_inc(stall_cycles_o);
            if (!valid_o && state == RUN)        empty_cycles_o   <= sat_inc(empty_cycles_o);
            if (redirect_i)                      redirect_count_o <= sat_inc(redirect_count_o);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] addr_o;
    logic        icache_valid_i = 1'b0;
    logic [31:0] icache_data_i = 32'h0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic [31:0] instr_o, pc_o;
    logic        valid_o;
    logic        ready_i = 1'b0;
`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0] stall_cycles_o, empty_cycles_o, redirect_count_o;
`endif

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .PC_STEP(32'd1)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .addr_o         (addr_o),
        .icache_valid_i (icache_valid_i),
        .icache_data_i  (icache_data_i),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .instr_o        (instr_o),
        .pc_o           (pc_o),
        .valid_o        (valid_o),
        .ready_i        (ready_i)
`ifdef FETCH_QUEUE_STATS_EN
        ,
        .stall_cycles_o   (stall_cycles_o),
        .empty_cycles_o   (empty_cycles_o),
        .redirect_count_o (redirect_count_o)
`endif
    );

    // Reference model: queue of {pc, instr}, fetch PC, flush flag, counters.
    logic [63:0] mq[$];
    logic [31:0] m_pc;
    bit          m_flush;
    logic [31:0] m_stall, m_empty, m_redc;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA000_0000 + a;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        bit          vld, pop, push, full;
        logic [63:0] ent;
        if (rst_i) begin
            mq.delete();
            m_pc = RESET_PC; m_flush = 0;
            m_stall = 0; m_empty = 0; m_redc = 0;
            return;
        end
        vld  = (mq.size() != 0);
        full = (mq.size() == DEPTH);
        pop  = vld && ready_i && !redirect_i;
        if (icache_valid_i && full && !pop) m_stall++;
        if (!vld && !m_flush) m_empty++;
        if (redirect_i) begin
            mq.delete();
            m_pc = redirect_pc_i; m_flush = 1; m_redc++;
            return;
        end
        push = !m_flush && icache_valid_i && (!full || pop);
        if (pop) ent = mq.pop_front();
        if (push) begin
            mq.push_back({m_pc, icache_data_i});
            m_pc = m_pc + 32'd1;
        end
        m_flush = 0;
    endtask

    task automatic check_all();
        logic [63:0] h;
        check("addr_o", addr_o, m_pc);
        check("valid_o", {31'h0, valid_o}, {31'h0, mq.size() != 0});
        if (mq.size() != 0) begin
            h = mq[0];
            check("pc_o", pc_o, h[63:32]);
            check("instr_o", instr_o, h[31:0]);
        end
`ifdef FETCH_QUEUE_STATS_EN
        check("stall_cycles_o", stall_cycles_o, m_stall);
        check("empty_cycles_o", empty_cycles_o, m_empty);
        check("redirect_count_o", redirect_count_o, m_redc);
`endif
    endtask

    // Called at a negedge: drive, clock, compare on the following negedge.
    task automatic step(input logic r, input logic iv, input logic red,
                        input logic [31:0] rpc, input logic rdy);
        rst_i          = r;
        icache_valid_i = iv;
        icache_data_i  = mem_word(addr_o);
        redirect_i     = red;
        redirect_pc_i  = rpc;
        ready_i        = rdy;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        // Reset state
        check("rst_valid", {31'h0, valid_o}, 32'h0);
        check("rst_addr", addr_o, RESET_PC);
        check("rst_pc_o", pc_o, 32'h0);
        check("rst_instr_o", instr_o, 32'h0);

        // Streaming: one entry per cycle, one cycle after push
        step(0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            step(0, 1, 0, 0, 1);
            check("stream_pc", pc_o, k);
            check("stream_instr", instr_o, 32'hA000_0000 + k);
        end

        // Back-pressure: exactly DEPTH pushes, PC frozen, then lossless drain
        do_reset();
        for (int k = 0; k < 7; k++) step(0, 1, 0, 0, 0);
        check("bp_addr_frozen", addr_o, 32'd4);
        check("bp_valid", {31'h0, valid_o}, 32'h1);
        for (int k = 0; k < 5; k++) begin
            check("bp_drain_pc", pc_o, k);
            step(0, 1, 0, 0, 1);
        end
        // Full with push+pop over a pointer wrap
        for (int k = 0; k < 10; k++) step(0, 1, 0, 0, 1);
        check("wrap_pc", pc_o, 32'd15);
        check("wrap_addr", addr_o, 32'd19);

        // Redirect with 3 queued entries
        do_reset();
        for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0);
        step(0, 1, 1, 32'h100, 0);
        check("redir_valid", {31'h0, valid_o}, 32'h0);
        check("redir_addr", addr_o, 32'h100);
        step(0, 1, 0, 0, 1);
        check("flush_valid", {31'h0, valid_o}, 32'h0);
        check("flush_addr", addr_o, 32'h100);
        step(0, 1, 0, 0, 0);
        check("redir_first_pc", pc_o, 32'h100);
        check("redir_first_instr", instr_o, 32'hA000_0100);

        // Reset overrides redirect while full
        for (int k = 0; k < 4; k++) step(0, 1, 0, 0, 0);
        step(1, 1, 1, 32'h55, 1);
        check("rstov_valid", {31'h0, valid_o}, 32'h0);
        check("rstov_addr", addr_o, RESET_PC);
        step(0, 1, 0, 0, 0);
        check("rstov_run_pc", pc_o, RESET_PC);

`ifdef FETCH_QUEUE_STATS_EN
        do_reset();
        for (int k = 0; k < 4; k++) step(0, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) step(0, 1, 0, 0, 0);
        step(0, 0, 1, 32'h40, 0);
        step(0, 0, 1, 32'h80, 0);
        check("stats_stall_lit", stall_cycles_o, 32'd5);
        check("stats_redir_lit", redirect_count_o, 32'd2);
`endif

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 24) == 0),
                 $urandom_range(0, 4095),
                 ($urandom_range(0, 9) < 6));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
